// File: rtl/reg_native_if_pkg.sv
// Shared types and helpers for the native register-interface address decoder.
package reg_native_if_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // Widest address the select helper accepts; callers zero-extend into it.
  localparam int unsigned MAX_ADDR_W = 128;

  localparam logic [1023:0] ERR_RDATA = '0;

  function automatic int unsigned sel_idx(input logic [MAX_ADDR_W-1:0] addr,
                                          input int unsigned           lsb,
                                          input int unsigned           w);
    logic [MAX_ADDR_W-1:0] shifted;
    shifted = addr >> lsb;
    return 32'(shifted) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/reg_native_if_decoder_wdog.sv
// Ack-timeout counter: cleared when a request goes outstanding, counts while waiting.
module reg_native_if_wdog #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturating increment keeps the disabled (TIMEOUT_CYC == 0) case from wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (TIMEOUT_CYC == 0) begin : g_no_timeout
      assign expire = 1'b0;
    end else begin : g_timeout
      assign expire = en && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end
  endgenerate

endmodule

// File: rtl/reg_native_if_decoder.sv
// Routes one native register request to one of N_SLV slaves by address field,
// with unmapped-address error response and an ack-timeout watchdog.
module reg_native_if_decoder
  import reg_native_if_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned N_SLV       = 4,
  parameter int unsigned SEL_LSB     = 12,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_vld,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic                        ack_vld,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        err,
  output logic [N_SLV-1:0]            s_req_vld,
  output logic [N_SLV-1:0]            s_wr_en,
  output logic [N_SLV-1:0]            s_rd_en,
  output logic [ADDR_WIDTH-1:0]       s_addr,
  output logic [DATA_WIDTH-1:0]       s_wr_data,
  input  logic [N_SLV-1:0]            s_ack_vld,
  input  logic [N_SLV*DATA_WIDTH-1:0] s_rd_data,
  input  logic [N_SLV-1:0]            s_err,
  output logic                        timeout_evt,
  output logic [ADDR_WIDTH-1:0]       timeout_addr,
  output logic                        proto_err
);

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    timeout_evt_q, timeout_evt_d;
  logic [ADDR_WIDTH-1:0]   timeout_addr_q, timeout_addr_d;
  logic                    proto_err_q, proto_err_d;

  logic [MAX_ADDR_W-1:0]   addr_ext;
  int unsigned             idx_raw;
  logic [SEL_W-1:0]        idx;
  logic [SEL_W-1:0]        cur;
  logic                    mapped;
  logic                    req_acc;
  logic                    fwd;
  logic                    sel_ack;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    sel_err;
  logic                    wd_clr;
  logic                    wd_en;
  logic                    wd_expire;

  assign addr_ext = MAX_ADDR_W'(addr);
  assign idx_raw  = sel_idx(addr_ext, SEL_LSB, SEL_W);
  assign idx      = SEL_W'(idx_raw);
  assign mapped   = idx_raw < N_SLV;
  assign req_acc  = req_vld & (wr_en | rd_en);

  // In IDLE the slave being looked at is the one just decoded; in BUSY it is the latched one.
  assign cur = (state_q == S_IDLE) ? idx : sel_q;

  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    sel_err   = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if (cur == SEL_W'(i)) begin
        sel_ack   = s_ack_vld[i];
        sel_rdata = s_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_err   = s_err[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_SLV; gi++) begin : g_fwd
      assign s_req_vld[gi] = fwd && (idx == SEL_W'(gi));
      assign s_wr_en[gi]   = fwd && (idx == SEL_W'(gi)) && wr_en;
      assign s_rd_en[gi]   = fwd && (idx == SEL_W'(gi)) && rd_en;
    end
  endgenerate

  assign s_addr    = fwd ? addr : '0;
  assign s_wr_data = fwd ? wr_data : '0;

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    addr_d         = addr_q;
    timeout_evt_d  = 1'b0;
    timeout_addr_d = timeout_addr_q;
    proto_err_d    = 1'b0;
    fwd            = 1'b0;
    ack_vld        = 1'b0;
    rd_data        = '0;
    err            = 1'b0;
    wd_clr         = 1'b0;
    wd_en          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_acc) begin
          if (mapped) begin
            fwd = 1'b1;
            if (sel_ack) begin
              ack_vld = 1'b1;
              rd_data = sel_rdata;
              err     = sel_err;
            end else begin
              state_d = S_BUSY;
              sel_d   = idx;
              addr_d  = addr;
              wd_clr  = 1'b1;
            end
          end else begin
            ack_vld = 1'b1;
            err     = 1'b1;
            rd_data = DATA_WIDTH'(ERR_RDATA);
          end
        end
      end
      S_BUSY: begin
        proto_err_d = req_acc;
        // A real ack in the expiry cycle takes priority over the forced error.
        if (sel_ack) begin
          ack_vld = 1'b1;
          rd_data = sel_rdata;
          err     = sel_err;
          state_d = S_IDLE;
        end else begin
          wd_en = 1'b1;
          if (wd_expire) begin
            ack_vld        = 1'b1;
            err            = 1'b1;
            rd_data        = DATA_WIDTH'(ERR_RDATA);
            timeout_evt_d  = 1'b1;
            timeout_addr_d = addr_q;
            state_d        = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      sel_q          <= '0;
      addr_q         <= '0;
      timeout_evt_q  <= 1'b0;
      timeout_addr_q <= '0;
      proto_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      addr_q         <= addr_d;
      timeout_evt_q  <= timeout_evt_d;
      timeout_addr_q <= timeout_addr_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign timeout_evt  = timeout_evt_q;
  assign timeout_addr = timeout_addr_q;
  assign proto_err    = proto_err_q;

  reg_native_if_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr),
    .en    (wd_en),
    .expire(wd_expire)
  );

endmodule

// File: tb/tb_reg_native_if_decoder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level reference model (outstanding request + elapsed-cycle timer).
module tb_reg_native_if_decoder;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int TO = 8;

  logic            clk;
  logic            rst_n;
  logic            req_vld, wr_en, rd_en;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wr_data;
  logic            ack_vld, err;
  logic [DW-1:0]   rd_data;
  logic [NS-1:0]   s_req_vld, s_wr_en, s_rd_en;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wr_data;
  logic [NS-1:0]   s_ack_vld;
  logic [NS*DW-1:0] s_rd_data;
  logic [NS-1:0]   s_err;
  logic            timeout_evt, proto_err;
  logic [AW-1:0]   timeout_addr;

  int n_vec;
  int n_err;

  reg_native_if_decoder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_SLV(NS),
    .SEL_LSB(12), .SEL_W(2), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .ack_vld(ack_vld), .rd_data(rd_data), .err(err),
    .s_req_vld(s_req_vld), .s_wr_en(s_wr_en), .s_rd_en(s_rd_en),
    .s_addr(s_addr), .s_wr_data(s_wr_data),
    .s_ack_vld(s_ack_vld), .s_rd_data(s_rd_data), .s_err(s_err),
    .timeout_evt(timeout_evt), .timeout_addr(timeout_addr), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    req_vld = 0; wr_en = 0; rd_en = 0; addr = '0; wr_data = '0;
    s_ack_vld = '0; s_rd_data = {$urandom, $urandom, $urandom}; s_err = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    next_cycle();
    rst_n = 1;
    #1;
    n_vec++;
    if ({ack_vld, err, rd_data, s_req_vld, s_wr_en, s_rd_en, s_addr, s_wr_data} !== '0) begin
      n_err++;
      $display("FAIL reset_comb: ack=%b err=%b rd=%h sreq=%b addr=%h, required all 0",
               ack_vld, err, rd_data, s_req_vld, s_addr);
    end
    n_vec++;
    if ({timeout_evt, timeout_addr, proto_err} !== '0) begin
      n_err++;
      $display("FAIL reset_regs: tevt=%b taddr=%h perr=%b, required 0", timeout_evt, timeout_addr, proto_err);
    end
    $display("reset: checked idle outputs");
  endtask

  task automatic test_write_zero_latency();
    logic [DW-1:0] wd;
    wd = $urandom;
    req_vld = 1; wr_en = 1; addr = 64'h1000; wr_data = wd; s_ack_vld = 3'b010;
    #1;
    n_vec++;
    if ({s_req_vld, s_wr_en, s_rd_en, s_wr_data, s_addr} !== {3'b010, 3'b010, 3'b000, wd, 64'h1000}) begin
      n_err++;
      $display("FAIL wr_fwd: sreq=%b swr=%b srd=%b swd=%h saddr=%h, required 010 010 000 %h 1000",
               s_req_vld, s_wr_en, s_rd_en, s_wr_data, s_addr, wd);
    end
    n_vec++;
    if ({ack_vld, err} !== 2'b10) begin
      n_err++;
      $display("FAIL wr_ack: ack=%b err=%b, required ack=1 err=0", ack_vld, err);
    end
    next_cycle();
    idle_inputs();
    s_ack_vld = 3'b010;
    #1;
    n_vec++;
    if (ack_vld !== 1'b0) begin
      n_err++;
      $display("FAIL wr_stays_idle: stray ack=%b, required 0", ack_vld);
    end
    next_cycle();
    idle_inputs();
    $display("write 0x1000: zero-latency ack data=%h", wd);
  endtask

  task automatic test_read_delayed();
    req_vld = 1; rd_en = 1; addr = 64'h2004;
    #1;
    n_vec++;
    if ({s_req_vld, s_rd_en, s_wr_en, ack_vld} !== {3'b100, 3'b100, 3'b000, 1'b0}) begin
      n_err++;
      $display("FAIL rd_fwd: sreq=%b srd=%b swr=%b ack=%b, required 100 100 000 0",
               s_req_vld, s_rd_en, s_wr_en, ack_vld);
    end
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      idle_inputs();
      s_ack_vld = 3'b011;
      #1;
      n_vec++;
      if ({ack_vld, s_req_vld} !== 4'b0000) begin
        n_err++;
        $display("FAIL rd_wait%0d: ack=%b sreq=%b, required 0 000", k, ack_vld, s_req_vld);
      end
    end
    next_cycle();
    idle_inputs();
    s_ack_vld = 3'b100;
    s_rd_data[2*DW +: DW] = 32'hDEADBEEF;
    #1;
    n_vec++;
    if ({ack_vld, err, rd_data} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL rd_ack: ack=%b err=%b rd=%h, required 1 0 deadbeef", ack_vld, err, rd_data);
    end
    next_cycle();
    idle_inputs();
    $display("read 0x2004: ack after 3 cycles rd=deadbeef");
  endtask

  task automatic test_unmapped();
    req_vld = 1; rd_en = 1; addr = 64'h3000; s_ack_vld = 3'b111; s_err = 3'b000;
    #1;
    n_vec++;
    if ({ack_vld, err, rd_data, s_req_vld, s_addr} !== {1'b1, 1'b1, 32'h0, 3'b000, 64'h0}) begin
      n_err++;
      $display("FAIL unmapped: ack=%b err=%b rd=%h sreq=%b saddr=%h, required 1 1 0 000 0",
               ack_vld, err, rd_data, s_req_vld, s_addr);
    end
    next_cycle();
    idle_inputs();
    $display("read 0x3000: unmapped error ack");
  endtask

  task automatic test_timeout();
    logic [AW-1:0] a;
    a = {$urandom, $urandom};
    a[13:12] = 2'd0;
    req_vld = 1; rd_en = 1; addr = a;
    #1;
    n_vec++;
    if ({s_req_vld, ack_vld} !== 4'b0010) begin
      n_err++;
      $display("FAIL to_fwd: sreq=%b ack=%b, required 001 0", s_req_vld, ack_vld);
    end
    for (int k = 1; k < TO; k++) begin
      next_cycle();
      idle_inputs();
      s_ack_vld = 3'b110;
      #1;
      n_vec++;
      if (ack_vld !== 1'b0 || timeout_evt !== 1'b0) begin
        n_err++;
        $display("FAIL to_wait%0d: ack=%b tevt=%b, required 0 0", k, ack_vld, timeout_evt);
      end
    end
    next_cycle();
    idle_inputs();
    #1;
    n_vec++;
    if ({ack_vld, err, rd_data} !== {1'b1, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL to_ack: ack=%b err=%b rd=%h, required 1 1 0", ack_vld, err, rd_data);
    end
    next_cycle();
    s_ack_vld = 3'b001;
    #1;
    n_vec++;
    if ({timeout_evt, timeout_addr, ack_vld} !== {1'b1, a, 1'b0}) begin
      n_err++;
      $display("FAIL to_evt: tevt=%b taddr=%h late_ack=%b, required 1 %h 0", timeout_evt, timeout_addr, ack_vld, a);
    end
    next_cycle();
    idle_inputs();
    n_vec++;
    if (timeout_evt !== 1'b0) begin
      n_err++;
      $display("FAIL to_evt_pulse: tevt=%b, required 0", timeout_evt);
    end
    $display("timeout: addr=%h acked with err after %0d cycles", a, TO);
  endtask

  task automatic test_busy_proto();
    req_vld = 1; wr_en = 1; addr = 64'h40; wr_data = $urandom;
    next_cycle();
    idle_inputs();
    req_vld = 1; wr_en = 1; addr = 64'h2000; s_ack_vld = 3'b100;
    #1;
    n_vec++;
    if ({ack_vld, s_req_vld} !== 4'b0000) begin
      n_err++;
      $display("FAIL busy_drop: ack=%b sreq=%b, required 0 000", ack_vld, s_req_vld);
    end
    next_cycle();
    idle_inputs();
    s_ack_vld = 3'b001; s_err = 3'b001;
    s_rd_data[0 +: DW] = 32'h0BAD_F00D;
    #1;
    n_vec++;
    if ({proto_err, ack_vld, err, rd_data} !== {1'b1, 1'b1, 1'b1, 32'h0BADF00D}) begin
      n_err++;
      $display("FAIL busy_complete: perr=%b ack=%b err=%b rd=%h, required 1 1 1 0badf00d",
               proto_err, ack_vld, err, rd_data);
    end
    next_cycle();
    idle_inputs();
    n_vec++;
    if (proto_err !== 1'b0) begin
      n_err++;
      $display("FAIL perr_pulse: perr=%b, required 0", proto_err);
    end
    $display("busy: request during BUSY dropped, proto_err pulsed");
  endtask

  task automatic test_reset_mid();
    req_vld = 1; rd_en = 1; addr = 64'h1008;
    next_cycle();
    idle_inputs();
    rst_n = 0;
    next_cycle();
    rst_n = 1;
    s_ack_vld = 3'b010;
    #1;
    n_vec++;
    if ({ack_vld, err, rd_data, s_req_vld, timeout_evt, proto_err} !== '0) begin
      n_err++;
      $display("FAIL rst_mid: ack=%b err=%b rd=%h sreq=%b, required all 0", ack_vld, err, rd_data, s_req_vld);
    end
    next_cycle();
    idle_inputs();
    req_vld = 1; wr_en = 1; addr = 64'h10; wr_data = 32'h1234_5678; s_ack_vld = 3'b001;
    #1;
    n_vec++;
    if ({s_req_vld, s_wr_data, ack_vld, err} !== {3'b001, 32'h12345678, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL rst_mid_next: sreq=%b swd=%h ack=%b err=%b, required 001 12345678 1 0",
               s_req_vld, s_wr_data, ack_vld, err);
    end
    next_cycle();
    idle_inputs();
    $display("reset mid-transaction: returned to IDLE");
  endtask

  task automatic test_random(input int n_cycles);
    bit            m_busy;
    int            m_sel, m_start, cyc, idx;
    logic [AW-1:0] m_addr, m_taddr;
    bit            acc, nb, n_tevt, n_perr;
    logic          e_ack, e_err;
    logic [DW-1:0] e_rd;
    logic [NS-1:0] e_sreq, e_swr, e_srd;
    logic [AW-1:0] e_saddr;
    logic [DW-1:0] e_swd;
    int            n_acks;
    rst_n = 0;
    idle_inputs();
    next_cycle();
    rst_n = 1;
    m_busy = 0; m_sel = 0; m_start = 0; cyc = 0; m_addr = '0; m_taddr = '0; n_acks = 0;
    for (int t = 0; t < n_cycles; t++) begin
      req_vld = ($urandom_range(0, 2) == 0);
      wr_en = $urandom; rd_en = $urandom;
      addr = {$urandom, $urandom};
      wr_data = $urandom;
      for (int s = 0; s < NS; s++) s_ack_vld[s] = ($urandom_range(0, 5) == 0);
      s_rd_data = {$urandom, $urandom, $urandom};
      s_err = 3'($urandom);
      #1;
      acc = req_vld && (wr_en || rd_en);
      idx = int'(addr[13:12]);
      e_ack = 0; e_err = 0; e_rd = '0; e_sreq = '0; e_swr = '0; e_srd = '0; e_saddr = '0; e_swd = '0;
      nb = m_busy; n_tevt = 0; n_perr = 0;
      if (!m_busy) begin
        if (acc && idx < NS) begin
          e_sreq[idx] = 1; e_swr[idx] = wr_en; e_srd[idx] = rd_en;
          e_saddr = addr; e_swd = wr_data;
          if (s_ack_vld[idx]) begin
            e_ack = 1; e_rd = s_rd_data[idx*DW +: DW]; e_err = s_err[idx];
          end else begin
            nb = 1; m_sel = idx; m_addr = addr; m_start = cyc;
          end
        end else if (acc) begin
          e_ack = 1; e_err = 1;
        end
      end else begin
        n_perr = acc;
        if (s_ack_vld[m_sel]) begin
          e_ack = 1; e_rd = s_rd_data[m_sel*DW +: DW]; e_err = s_err[m_sel]; nb = 0;
        end else if (cyc - m_start == TO) begin
          e_ack = 1; e_err = 1; n_tevt = 1; m_taddr = m_addr; nb = 0;
        end
      end
      n_vec++;
      if ({ack_vld, err, rd_data} !== {e_ack, e_err, e_rd}) begin
        n_err++;
        $display("FAIL rand_up c%0d: ack=%b err=%b rd=%h, required %b %b %h",
                 t, ack_vld, err, rd_data, e_ack, e_err, e_rd);
      end
      n_vec++;
      if ({s_req_vld, s_wr_en, s_rd_en, s_addr, s_wr_data} !== {e_sreq, e_swr, e_srd, e_saddr, e_swd}) begin
        n_err++;
        $display("FAIL rand_fwd c%0d: sreq=%b swr=%b srd=%b saddr=%h, required %b %b %b %h",
                 t, s_req_vld, s_wr_en, s_rd_en, s_addr, e_sreq, e_swr, e_srd, e_saddr);
      end
      if (e_ack) n_acks++;
      next_cycle();
      cyc++;
      m_busy = nb;
      n_vec++;
      if ({timeout_evt, timeout_addr, proto_err} !== {n_tevt, m_taddr, n_perr}) begin
        n_err++;
        $display("FAIL rand_regs c%0d: tevt=%b taddr=%h perr=%b, required %b %h %b",
                 t, timeout_evt, timeout_addr, proto_err, n_tevt, m_taddr, n_perr);
      end
    end
    idle_inputs();
    $display("random: %0d cycles, %0d upstream acks expected", n_cycles, n_acks);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 0;
    idle_inputs();
    next_cycle();
    test_reset();
    test_write_zero_latency();
    test_read_delayed();
    test_unmapped();
    test_timeout();
    test_busy_proto();
    test_reset_mid();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_native_if_decoder.md
Name: reg_native_if_decoder

Overview:
- Downstream consumer of the APB-to-register native-interface bridge.
- Takes one upstream native request (req_vld/wr_en/rd_en/addr/wr_data) and routes it to one of N_SLV register-block slaves, selected by an address field.
- Returns the selected slave's ack_vld/rd_data/err upstream.
- Adds an unmapped-address error response and an ack-timeout watchdog, so a dead slave cannot hang the APB bus.

Parameters:
- ADDR_WIDTH, 64, address width; matches the bridge.
- DATA_WIDTH, 32, data width.
- N_SLV, 4, number of slaves; 1..2**SEL_W.
- SEL_LSB, 12, lowest address bit of the slave-select field.
- SEL_W, 2, width of the slave-select field.
- TIMEOUT_CYC, 256, cycles in BUSY before a forced error ack; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_vld  in  1  upstream request pulse
- wr_en  in  1  upstream write
- rd_en  in  1  upstream read
- addr  in  ADDR_WIDTH  upstream address
- wr_data  in  DATA_WIDTH  upstream write data
- ack_vld  out  1  upstream ack
- rd_data  out  DATA_WIDTH  upstream read data
- err  out  1  upstream error
- s_req_vld  out  N_SLV  per-slave request pulse
- s_wr_en  out  N_SLV  per-slave write
- s_rd_en  out  N_SLV  per-slave read
- s_addr  out  ADDR_WIDTH  broadcast address (full, unmodified)
- s_wr_data  out  DATA_WIDTH  broadcast write data
- s_ack_vld  in  N_SLV  per-slave ack
- s_rd_data  in  N_SLV*DATA_WIDTH  per-slave read data; slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_err  in  N_SLV  per-slave error
- timeout_evt  out  1  registered 1-cycle pulse on a timeout
- timeout_addr  out  ADDR_WIDTH  address of the last timed-out request
- proto_err  out  1  registered 1-cycle pulse when a request arrives while BUSY

Behaviour:
- Clock and reset: single clock clk; rst_n synchronous and active-low, sampled on posedge clk.
- Reset values: state=IDLE, cnt=0, sel_q=0, timeout_evt=0, timeout_addr=0, proto_err=0.
  - All combinational outputs evaluate to 0 in IDLE with no request: ack_vld, rd_data, err, s_req_vld, s_wr_en, s_rd_en, s_addr, s_wr_data.
- Request accepted: upstream req_vld & (wr_en|rd_en). req_vld with neither wr_en nor rd_en is ignored (nothing forwarded, no ack).
- Decode: idx = addr[SEL_LSB +: SEL_W]. Mapped if idx < N_SLV.
- IDLE, mapped request, same cycle:
  - Forward combinationally: s_req_vld[idx]=1, s_wr_en[idx]=wr_en, s_rd_en[idx]=rd_en; other slaves' bits 0.
  - s_addr=addr and s_wr_data=wr_data while a request is forwarded, else 0.
  - If s_ack_vld[idx]=1 the same cycle: ack_vld=1, rd_data=s_rd_data[idx], err=s_err[idx] (zero-latency pass-through); stay IDLE.
  - Otherwise: sel_q<=idx, cnt<=0, go to BUSY.
- IDLE, unmapped request: ack_vld=1, err=1, rd_data=0 the same cycle; nothing forwarded; stay IDLE.
- BUSY:
  - ack_vld=s_ack_vld[sel_q], rd_data=s_rd_data[sel_q], err=s_err[sel_q] when that ack is high; otherwise all 0.
  - On ack: go to IDLE.
  - Else cnt<=cnt+1. If TIMEOUT_CYC!=0 and cnt==TIMEOUT_CYC-1: ack_vld=1, err=1, rd_data=0 that cycle; timeout_evt<=1; timeout_addr<=address captured at request (addr_q); go to IDLE.
  - Total ack latency on timeout: TIMEOUT_CYC cycles after the request cycle.
- Request while BUSY: not forwarded, not acked; proto_err<=1 next cycle.
- Acks from non-selected slaves in BUSY, and any s_ack_vld in IDLE without a matching request, are dropped.
  - A late ack from a timed-out slave that coincides with a new request to the same slave is taken as that request's ack. Slaves must never ack after TIMEOUT_CYC; this is a system requirement.
- Simultaneous ack and timeout in the same BUSY cycle: the real ack wins; no timeout_evt.
- Reset mid-transaction: return to IDLE; the in-flight request is abandoned with no ack; a later slave ack is dropped.
- cnt width is $clog2(TIMEOUT_CYC+1), minimum 1. It never wraps because it leaves BUSY at TIMEOUT_CYC-1.
  - With TIMEOUT_CYC=0, cnt saturates and has no effect.

Decomposition:
- reg_native_if_pkg:
  - state enum {S_IDLE, S_BUSY}
  - function sel_idx(addr) returning the select field
  - constant ERR_RDATA = '0
- One sub-module, reg_native_if_wdog: the cnt register, clear/enable inputs, expire output, TIMEOUT_CYC parameter.

Test Plan:
- Write to addr 0x1000 (idx 1); s_ack_vld[1] same cycle -> ack_vld same cycle; s_req_vld=4'b0010; s_wr_data=wr_data; state stays IDLE.
- Read addr 0x2004 (idx 2); s_ack_vld[2] 3 cycles later with rd_data 0xDEADBEEF, s_err=0 -> upstream ack in exactly that cycle with 0xDEADBEEF, err=0.
- N_SLV=3: read addr 0x3000 (idx 3) -> same-cycle ack_vld=1, err=1, rd_data=0; s_req_vld=0.
- TIMEOUT_CYC=8, read to idx 0, no ack -> ack_vld=1, err=1 8 cycles after the request; timeout_evt pulses for 1 cycle; timeout_addr=request addr; a later s_ack_vld[0] is dropped.
- In BUSY, s_ack_vld[3] and a new req_vld -> neither acked nor forwarded; proto_err pulses; s_ack_vld[sel_q] then completes normally.
- rst_n low for 1 cycle in BUSY -> IDLE, all outputs 0; a next write to idx 0 forwards and acks normally.
